// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Pipeline memory stage. Non-memory instructions pass straight to the
// registered writeback outputs with one cycle of latency. lw/sw are held
// while a data-memory access is in flight; the access is presented on the
// dmem_* port and completes when dmem_ready is seen. A flush during an
// access lets the access finish but turns its result into a bubble.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   in_valid/in_insn/in_aluResult/in_storeData/in_exception
//                         instruction offered by the previous stage
//   flush                 kill the offered or in-flight instruction
//   in_ready              1 when the stage can accept (IDLE)
//   dmem_req/wren/addr/wdata  memory request, held stable until dmem_ready
//   dmem_ready/dmem_rdata     memory completion and load data
//   out_*                 registered writeback outputs (bubble = all zero)
//   stall_count           saturating count of ACCESS cycles without ready
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready to accept; non-mem-ops retire here in one cycle
// ACCESS | mem-op held, request on dmem_*, waiting for dmem_ready
// ---------------------------------------------------------------------------
module memory_stage (
   input  logic        clock,
   input  logic        reset,

   input  logic        in_valid,
   input  logic [31:0] in_insn,
   input  logic [31:0] in_aluResult,
   input  logic [31:0] in_storeData,
   input  logic        in_exception,
   input  logic        flush,
   output logic        in_ready,

   output logic        dmem_req,
   output logic        dmem_wren,
   output logic [11:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,

   output logic        out_valid,
   output logic [31:0] out_insn,
   output logic [31:0] out_aluResult,
   output logic [31:0] out_dmemData,
   output logic        out_exception,
   output logic [15:0] stall_count
);

   localparam logic [4:0] OP_LW = 5'b01000;
   localparam logic [4:0] OP_SW = 5'b00111;

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} stateType;

   stateType    state;
   stateType    stateNext;

   // holding register for the instruction in flight
   logic [31:0] heldInsn;
   logic [31:0] heldAlu;
   logic [31:0] heldStore;
   logic        heldExc;
   logic        holdLoad;

   logic        killFlag;
   logic        killNext;
   logic        stallInc;

   logic        outValidNext;
   logic [31:0] outInsnNext;
   logic [31:0] outAluNext;
   logic [31:0] outDataNext;
   logic        outExcNext;

   logic [4:0]  inOpcode;
   logic        inIsMemOp;
   logic        accept;
   logic        heldIsSw;
   logic        heldIsLw;

   // An exception flag turns any opcode into a plain pass-through, so a
   // faulting lw/sw can never reach the memory port.
   assign inOpcode  = in_insn[31:27];
   assign inIsMemOp = ((inOpcode == OP_LW) || (inOpcode == OP_SW)) && !in_exception;
   assign accept    = (state == IDLE) && in_valid && !flush;
   assign heldIsSw  = (heldInsn[31:27] == OP_SW);
   assign heldIsLw  = (heldInsn[31:27] == OP_LW);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext    = state;
      killNext     = killFlag;
      holdLoad     = 1'b0;
      stallInc     = 1'b0;
      outValidNext = 1'b0;
      outInsnNext  = 32'd0;
      outAluNext   = 32'd0;
      outDataNext  = 32'd0;
      outExcNext   = 1'b0;
      in_ready     = 1'b0;
      dmem_req     = 1'b0;
      dmem_wren    = 1'b0;
      dmem_addr    = 12'd0;
      dmem_wdata   = 32'd0;

      case (state)
         IDLE: begin
            in_ready = 1'b1;
            killNext = 1'b0;
            if (accept) begin
               if (inIsMemOp) begin
                  holdLoad  = 1'b1;
                  stateNext = ACCESS;
               end else begin
                  outValidNext = 1'b1;
                  outInsnNext  = in_insn;
                  outAluNext   = in_aluResult;
                  outExcNext   = in_exception;
               end
            end
         end

         ACCESS: begin
            dmem_req   = 1'b1;
            dmem_wren  = heldIsSw;
            dmem_addr  = heldAlu[11:0];
            dmem_wdata = heldStore;
            if (!dmem_ready) begin
               stallInc = 1'b1;
               if (flush) begin
                  killNext = 1'b1;
               end
            end else begin
               stateNext = IDLE;
               killNext  = 1'b0;
               // a flush arriving with ready still kills the result
               if (!killFlag && !flush) begin
                  outValidNext = 1'b1;
                  outInsnNext  = heldInsn;
                  outAluNext   = heldAlu;
                  outExcNext   = heldExc;
                  outDataNext  = heldIsLw ? dmem_rdata : 32'd0;
               end
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         heldInsn  <= 32'd0;
         heldAlu   <= 32'd0;
         heldStore <= 32'd0;
         heldExc   <= 1'b0;
      end else if (holdLoad) begin
         heldInsn  <= in_insn;
         heldAlu   <= in_aluResult;
         heldStore <= in_storeData;
         heldExc   <= in_exception;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         killFlag <= 1'b0;
      end else begin
         killFlag <= killNext;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid     <= 1'b0;
         out_insn      <= 32'd0;
         out_aluResult <= 32'd0;
         out_dmemData  <= 32'd0;
         out_exception <= 1'b0;
      end else begin
         out_valid     <= outValidNext;
         out_insn      <= outInsnNext;
         out_aluResult <= outAluNext;
         out_dmemData  <= outDataNext;
         out_exception <= outExcNext;
      end
   end

   // saturates instead of wrapping so long stalls stay visible
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_count <= 16'd0;
      end else if (stallInc && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

   localparam logic [4:0] OP_LW  = 5'b01000;
   localparam logic [4:0] OP_SW  = 5'b00111;
   localparam logic [4:0] OP_ADD = 5'b00000;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_insn;
   logic [31:0] in_aluResult;
   logic [31:0] in_storeData;
   logic        in_exception;
   logic        flush;
   logic        in_ready;
   logic        dmem_req;
   logic        dmem_wren;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        out_valid;
   logic [31:0] out_insn;
   logic [31:0] out_aluResult;
   logic [31:0] out_dmemData;
   logic        out_exception;
   logic [15:0] stall_count;

   memory_stage dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_insn      (in_insn),
      .in_aluResult (in_aluResult),
      .in_storeData (in_storeData),
      .in_exception (in_exception),
      .flush        (flush),
      .in_ready     (in_ready),
      .dmem_req     (dmem_req),
      .dmem_wren    (dmem_wren),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ready   (dmem_ready),
      .dmem_rdata   (dmem_rdata),
      .out_valid    (out_valid),
      .out_insn     (out_insn),
      .out_aluResult(out_aluResult),
      .out_dmemData (out_dmemData),
      .out_exception(out_exception),
      .stall_count  (stall_count)
   );

   always #5 clock = ~clock;

   int nChecks = 0;
   int nFails  = 0;
   bit cmpEn   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one pending memory transaction at most, plus the
   // value the writeback register must hold after each edge.
   bit          mBusy;
   bit          mKill;
   logic [31:0] mInsn, mAlu, mStore;
   int          mStall;
   logic        eValid, eExc;
   logic [31:0] eInsn, eAlu, eData;

   function automatic bit isMemOp(input logic [31:0] insn, input logic exc);
      return !exc && (insn[31:27] == OP_LW || insn[31:27] == OP_SW);
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mBusy = 0; mKill = 0; mInsn = 0; mAlu = 0; mStore = 0; mStall = 0;
         eValid = 0; eExc = 0; eInsn = 0; eAlu = 0; eData = 0;
      end else begin
         eValid = 0; eExc = 0; eInsn = 0; eAlu = 0; eData = 0;
         if (!mBusy) begin
            if (in_valid && !flush) begin
               if (isMemOp(in_insn, in_exception)) begin
                  mBusy = 1; mInsn = in_insn; mAlu = in_aluResult; mStore = in_storeData;
               end else begin
                  eValid = 1; eInsn = in_insn; eAlu = in_aluResult; eExc = in_exception;
               end
            end
         end else if (!dmem_ready) begin
            if (mStall < 65535) mStall++;
            if (flush) mKill = 1;
         end else begin
            if (!mKill && !flush) begin
               eValid = 1; eInsn = mInsn; eAlu = mAlu;
               eData  = (mInsn[31:27] == OP_LW) ? dmem_rdata : 32'd0;
            end
            mBusy = 0; mKill = 0;
         end
      end
   end

   always @(negedge clock) begin
      if (cmpEn) begin
         check("in_ready",      32'(in_ready),      32'(!mBusy));
         check("dmem_req",      32'(dmem_req),      32'(mBusy));
         check("dmem_wren",     32'(dmem_wren),     32'(mBusy && mInsn[31:27] == OP_SW));
         check("dmem_addr",     32'(dmem_addr),     32'(mBusy ? mAlu[11:0] : 12'd0));
         check("dmem_wdata",    dmem_wdata,         mBusy ? mStore : 32'd0);
         check("out_valid",     32'(out_valid),     32'(eValid));
         check("out_insn",      out_insn,           eInsn);
         check("out_aluResult", out_aluResult,      eAlu);
         check("out_dmemData",  out_dmemData,       eData);
         check("out_exception", 32'(out_exception), 32'(eExc));
         check("stall_count",   32'(stall_count),   32'(mStall));
      end
   end

   task automatic setIn(input logic v, input logic [31:0] insn, input logic [31:0] alu,
                        input logic [31:0] sd, input logic exc, input logic fl,
                        input logic rdy, input logic [31:0] rd);
      in_valid = v; in_insn = insn; in_aluResult = alu; in_storeData = sd;
      in_exception = exc; flush = fl; dmem_ready = rdy; dmem_rdata = rd;
   endtask

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   initial begin
      logic [31:0] lwInsn, swInsn, addInsn;
      lwInsn  = {OP_LW, 27'h0000123};
      swInsn  = {OP_SW, 27'h0000456};
      addInsn = {OP_ADD, 27'h0000789};

      reset = 1'b1;
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      cmpEn = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset stall", 32'(stall_count), 32'd0);
      reset = 1'b0;

      // add passes through in one cycle
      setIn(1, addInsn, 32'd7, 0, 0, 0, 0, 0);
      step();
      check("add out_valid", 32'(out_valid), 32'd1);
      check("add out_alu", out_aluResult, 32'd7);
      check("add out_data", out_dmemData, 32'd0);
      check("add dmem_req", 32'(dmem_req), 32'd0);

      // lw, ready three cycles late
      setIn(1, lwInsn, 32'h0000_1004, 0, 0, 0, 0, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         setIn(0, 0, 0, 0, 0, 0, (i == 3), (i == 3) ? 32'hDEADBEEF : 32'h0);
         check("lw in_ready", 32'(in_ready), 32'd0);
         check("lw dmem_addr", 32'(dmem_addr), 32'h004);
         check("lw dmem_wren", 32'(dmem_wren), 32'd0);
         step();
      end
      check("lw out_valid", 32'(out_valid), 32'd1);
      check("lw out_data", out_dmemData, 32'hDEADBEEF);
      check("lw stall", 32'(stall_count), 32'd3);
      check("lw in_ready after", 32'(in_ready), 32'd1);

      // sw, ready immediately
      setIn(1, swInsn, 32'h0000_0010, 32'h55, 0, 0, 1, 0);
      step();
      setIn(0, 0, 0, 0, 0, 0, 1, 32'h1234);
      check("sw wren", 32'(dmem_wren), 32'd1);
      check("sw wdata", dmem_wdata, 32'h55);
      check("sw addr", 32'(dmem_addr), 32'h010);
      check("sw bubble", 32'(out_valid), 32'd0);
      step();
      check("sw out_valid", 32'(out_valid), 32'd1);
      check("sw out_data", out_dmemData, 32'd0);
      check("sw wren after", 32'(dmem_wren), 32'd0);

      // sw carrying an exception never touches memory
      setIn(1, swInsn, 32'h20, 32'h77, 1, 0, 0, 0);
      step();
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      check("exc out_exception", 32'(out_exception), 32'd1);
      check("exc out_valid", 32'(out_valid), 32'd1);
      check("exc dmem_req", 32'(dmem_req), 32'd0);
      check("exc dmem_wren", 32'(dmem_wren), 32'd0);

      // lw flushed mid-access still completes, result is a bubble
      setIn(1, lwInsn, 32'h30, 0, 0, 0, 0, 0);
      step();
      setIn(0, 0, 0, 0, 0, 1, 0, 0);
      step();
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      check("flush req held", 32'(dmem_req), 32'd1);
      step();
      setIn(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
      step();
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      check("flush out_valid", 32'(out_valid), 32'd0);
      check("flush out_insn", out_insn, 32'd0);
      check("flush in_ready", 32'(in_ready), 32'd1);
      check("flush stall", 32'(stall_count), 32'd5);

      // reset between edges during an access
      setIn(1, lwInsn, 32'h40, 0, 0, 0, 0, 0);
      step();
      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      #1 reset = 1'b1;
      #1;
      check("rst dmem_req", 32'(dmem_req), 32'd0);
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst stall", 32'(stall_count), 32'd0);
      reset = 1'b0;
      setIn(1, addInsn, 32'd9, 0, 0, 0, 0, 0);
      step();
      check("post-rst out_valid", 32'(out_valid), 32'd1);
      check("post-rst out_alu", out_aluResult, 32'd9);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         logic [4:0]  op;
         int unsigned sel;
         sel = $urandom_range(0, 3);
         op  = (sel == 0) ? OP_LW : (sel == 1) ? OP_SW : 5'($urandom);
         setIn($urandom_range(0, 3) != 0, {op, 27'($urandom)}, $urandom, $urandom,
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0, $urandom);
         step();
      end

      setIn(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      cmpEn = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clock  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-002 The module SHALL have these upstream ports: in_valid  in  1  instruction offered; in_insn  in  32  instruction; in_aluResult  in  32  ALU result / address; in_storeData  in  32  sw data; in_exception  in  1  ALU overflow flag; flush  in  1  kill incoming/in-flight instruction; in_ready  out  1  stage can accept.
REQ-003 The module SHALL have these data-memory ports: dmem_req  out  1  access request; dmem_wren  out  1  write enable; dmem_addr  out  12  word address; dmem_wdata  out  32  store data; dmem_ready  in  1  access complete; dmem_rdata  in  32  load data, valid with dmem_ready.
REQ-004 The module SHALL have these writeback-side ports, all registered: out_valid  out  1; out_insn  out  32  (bubble = 0); out_aluResult  out  32; out_dmemData  out  32; out_exception  out  1; stall_count  out  16  saturating count of ACCESS cycles.

Function
REQ-005 Decode SHALL use opcode = insn[31:27]: lw = 5'b01000, sw = 5'b00111; a mem-op is lw or sw with in_exception = 0.
REQ-006 The FSM SHALL have two states, IDLE and ACCESS; in_ready SHALL be 1 exactly in IDLE.
REQ-007 Accept SHALL occur on a rising edge where state = IDLE and in_valid = 1 and flush = 0.
REQ-008 On accept of a non-mem-op (including any instruction with in_exception = 1), the output register SHALL load insn, aluResult and exception, with out_dmemData = 0 and out_valid = 1 (latency 1 cycle); the stage SHALL remain in IDLE.
REQ-009 On accept of a mem-op, a holding register SHALL capture insn, aluResult, storeData and exception; the FSM SHALL go to ACCESS; and the output register SHALL load a bubble.
REQ-010 In IDLE with no accept (in_valid = 0, or flush = 1), the output register SHALL load a bubble: out_valid = 0, out_insn = 0, and the other data outputs = 0.
REQ-011 In ACCESS, the stage SHALL drive dmem_req = 1, dmem_addr = held aluResult[11:0], dmem_wren = 1 for sw and 0 for lw, and dmem_wdata = held storeData, all stable until dmem_ready; aluResult[31:12] SHALL be ignored.
REQ-012 Outside ACCESS, dmem_req, dmem_wren, dmem_addr and dmem_wdata SHALL be 0.
REQ-013 In ACCESS with dmem_ready = 0, the output register SHALL load a bubble and the state SHALL be held.
REQ-014 In ACCESS with dmem_ready = 1, the next edge SHALL load the output from the held instruction: out_dmemData = dmem_rdata for lw and 0 for sw, out_valid = 1, and the FSM SHALL return to IDLE.
REQ-015 A single-cycle memory response (dmem_ready already 1 in the first ACCESS cycle) SHALL give mem-op latency = 2 cycles from accept to out_valid.
REQ-016 In IDLE, flush = 1 SHALL discard the offered instruction; no memory access SHALL occur.
REQ-017 Flush = 1 during ACCESS SHALL set a kill flag; the request SHALL NOT be aborted and SHALL complete on dmem_ready, but the output SHALL load a bubble instead of the instruction, and the kill flag SHALL clear on return to IDLE.
REQ-018 A flush asserted in the same cycle as dmem_ready SHALL produce a bubble.
REQ-019 stall_count SHALL increment on every clock edge in ACCESS where dmem_ready = 0, SHALL saturate at 16'hFFFF, and SHALL never wrap.
REQ-020 An instruction with in_exception = 1 SHALL never cause dmem_req or dmem_wren, regardless of opcode.

Reset
REQ-021 On reset assertion, the stage SHALL immediately go to IDLE, clear the kill flag and holding register, and set all outputs to 0 except in_ready = 1.
REQ-022 Reset mid-ACCESS SHALL drop dmem_req asynchronously, and the pending result SHALL be discarded.
REQ-023 After reset deassertion, the first accept SHALL be possible on the first rising edge.

Verification
REQ-024 The bench SHALL cover: add (opcode 00000) with aluResult = 7, no exception -> next cycle out_valid = 1, out_aluResult = 7, out_dmemData = 0, dmem_req never 1.
REQ-025 The bench SHALL cover: lw with aluResult = 0x0000_1004 and dmem_ready 3 cycles late with rdata = 0xDEADBEEF -> dmem_addr = 0x004, in_ready = 0 for 4 cycles, out_dmemData = 0xDEADBEEF, stall_count = 3.
REQ-026 The bench SHALL cover: sw with storeData = 0x55, addr 0x010, ready immediate -> one cycle with dmem_wren = 1 and dmem_wdata = 0x55, then out_valid = 1 with out_dmemData = 0.
REQ-027 The bench SHALL cover: sw with in_exception = 1 -> dmem_req and dmem_wren stay 0, and next cycle out_exception = 1 and out_valid = 1.
REQ-028 The bench SHALL cover: lw accepted, flush pulsed during ACCESS, ready 2 cycles later -> access completes and output is a bubble (out_valid = 0, out_insn = 0).
REQ-029 The bench SHALL cover: reset asserted mid-ACCESS -> dmem_req = 0 without waiting for a clock edge, in_ready = 1, and stall_count = 0.
